wb_commit: RTL and testbench
============================

Name: wb_commit

Overview:
Commit-side consumer of the decoder's write_R/write_M enables. It takes one decoded instruction result per accepted transfer and writes the register file in a single cycle. Stores are driven to data memory over a req/ack handshake, and the pipeline is stalled while a store is outstanding. The block sits between the execute stage and the register file / data-memory port.

Parameters:
ACK_TIMEOUT, 255, cycles to wait for dmem_ack before aborting a store; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  execute stage presents a result
in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready
write_R  in  1  register write enable from decoder
write_M  in  1  memory write enable from decoder
rd  in  5  destination register
reg_data  in  32  value for rd
mem_addr  in  32  byte address of store
mem_wdata  in  32  store data, LSB-aligned
mem_size  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 illegal
rf_we  out  1  register file write strobe
rf_waddr  out  5  register file address
rf_wdata  out  32  register file data
dmem_req  out  1  store request
dmem_addr  out  32  word-aligned address
dmem_wdata  out  32  lane-replicated data
dmem_be  out  4  byte enables
dmem_ack  in  1  memory accepted store
err_misalign  out  1  one-cycle pulse: store dropped (misaligned or size 11)
err_timeout  out  1  one-cycle pulse: store aborted by timeout

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: all outputs 0 except in_ready, which is 1 in the first cycle after reset. FSM goes to IDLE and the timeout counter clears. An outstanding dmem_req drops at the reset edge, and no completion is reported.
- Register path: a transfer with write_R=1 gives rf_we=1 in the next cycle, with rf_waddr/rf_wdata registered from rd/reg_data. rf_we stays 0 when rd==0. Latency is 1 and the path is independent of the store FSM.
- Store path FSM, states IDLE and REQ:
  - IDLE: a transfer with write_M=1 and a legal, aligned access moves to REQ. dmem_* are registered and dmem_req=1 from the next cycle.
  - REQ: dmem_req and dmem_* stay stable until a cycle with dmem_ack=1, then the FSM returns to IDLE with dmem_req=0 in the following cycle.
  - dmem_ack while dmem_req=0 is ignored.
- in_ready = (state==IDLE). A store is accepted in IDLE, so the cycle after acceptance has in_ready=0. A register-only transfer in IDLE keeps in_ready=1, so back-to-back transfers are allowed.
- Alignment and lane rules:
  - half with addr[0]=1, word with addr[1:0]!=0, or size 11: store is dropped, err_misalign pulses in the next cycle, FSM stays IDLE. A write_R in the same transfer still executes.
  - dmem_addr = {mem_addr[31:2],2'b00}.
  - byte: be = 0001<<addr[1:0], wdata = {4{mem_wdata[7:0]}}.
  - half: be = 0011<<addr[1:0], wdata = {2{mem_wdata[15:0]}}.
  - word: be = 1111, wdata = mem_wdata.
- Timeout: the counter clears on entry to REQ and increments each REQ cycle without ack. When the count reaches ACK_TIMEOUT, dmem_req drops in the next cycle, err_timeout pulses, and the FSM returns to IDLE. If ack arrives in the same cycle the limit is reached, ack wins and there is no error.
- write_R and write_M both set: both actions are performed.
- Neither enable set (branch/jump): the transfer is consumed with no side effect.

Optional Feature:
WB_STORE_BUF_EN.
- Defined: a one-entry posted store. in_ready stays 1 in REQ for transfers with write_M=0. A transfer with write_M=1 in REQ is not accepted, because in_ready is 0 whenever in_valid && write_M && state==REQ. This combinational in_ready depends on in_valid and write_M.
- Undefined: in_ready = (state==IDLE) as above.

Decomposition:
- Package wb_pkg:
  - mem_size encodings SZ_B/SZ_H/SZ_W
  - state enum IDLE/REQ
  - default ACK_TIMEOUT constant
- One sub-module, store_lane_align: combinational; computes be, replicated wdata, aligned address and the illegal flag from mem_addr/mem_size/mem_wdata.

Test Plan:
- Reg write: write_R=1, rd=5, reg_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF. Repeat with rd=0 -> rf_we stays 0.
- Byte store, addr 0x1003, wdata 0xAB, ack after 3 cycles -> dmem_addr=0x1000, be=1000, wdata=0xABABABAB, req held 3 cycles, in_ready=0 throughout, IDLE after ack.
- Half store at addr 0x2001 -> no dmem_req, err_misalign pulses for one cycle, in_ready stays 1.
- ACK_TIMEOUT=4, ack never asserted -> dmem_req high 4 cycles then low, err_timeout pulses once, next store accepted.
- rst asserted in the 2nd cycle of REQ -> dmem_req=0 after that edge, no errors, in_ready=1.
- WB_STORE_BUF_EN: store outstanding, then a register-only write -> accepted with rf_we next cycle. A second store is held (in_ready=0) until ack.

Source files
------------

// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the write-back / commit block:
//   - mem_size encodings (SZ_B / SZ_H / SZ_W; 2'b11 is illegal)
//   - store FSM state enum (IDLE / REQ)
//   - default data-memory ack timeout and timeout counter width
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  localparam int ACK_TIMEOUT_DEFAULT = 255;
  localparam int TO_W_DEFAULT        = 8;

endpackage

// File: rtl/wb_commit_store_lane_align.sv
// ---------------------------------------------------------------------------
// store_lane_align
// Combinational store formatter. From the byte address, size and LSB-aligned
// store data it produces the word-aligned address, byte enables, the
// lane-replicated write data and a flag for accesses that must be dropped.
// Ports:
//   addr_i    [31:0] byte address of the store
//   size_i    [1:0]  00 byte, 01 half, 10 word, 11 illegal
//   wdata_i   [31:0] store data, LSB-aligned
//   addr_o    [31:0] word-aligned address
//   be_o      [3:0]  byte enables
//   wdata_o   [31:0] lane-replicated write data
//   illegal_o        misaligned access or illegal size
// ---------------------------------------------------------------------------
module store_lane_align
  import wb_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] addr_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        illegal_o
);

  assign addr_o = {addr_i[31:2], 2'b00};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    be_o      = 4'b0000;
    wdata_o   = wdata_i;
    illegal_o = 1'b0;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_i[1:0];
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o      = 4'b0011 << addr_i[1:0];
        wdata_o   = {2{wdata_i[15:0]}};
        illegal_o = addr_i[0];
      end
      SZ_W: begin
        be_o      = 4'b1111;
        illegal_o = (addr_i[1:0] != 2'b00);
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// ---------------------------------------------------------------------------
// wb_commit
// Commit-side consumer of the decoder write enables. Each accepted transfer
// may write the register file (one-cycle latency) and/or issue a store to
// data memory over a req/ack handshake; the pipeline is stalled while a
// store is outstanding. Misaligned/illegal stores are dropped with an error
// pulse, and a store with no ack for ACK_TIMEOUT cycles is aborted
// (ACK_TIMEOUT = 0 disables the timeout).
//
// Build option: `define WB_STORE_BUF_EN makes the outstanding store posted:
// transfers without write_M are still accepted while a store is in flight.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           execute-stage handshake
//   write_R, write_M              register / memory write enables
//   rd, reg_data                  register destination and value
//   mem_addr, mem_wdata, mem_size store address, data, size
//   rf_we, rf_waddr, rf_wdata     register file write port
//   dmem_req, dmem_addr, dmem_wdata, dmem_be, dmem_ack  data-memory port
//   err_misalign, err_timeout     one-cycle error pulses
// ---------------------------------------------------------------------------
module wb_commit
  import wb_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT,
  parameter int TO_W        = TO_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        write_R,
  input  logic        write_M,
  input  logic [4:0]  rd,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [1:0]  mem_size,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  output logic        err_misalign,
  output logic        err_timeout
);

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q;
  logic        err_misalign_q, err_timeout_q;

  logic [31:0] al_addr, al_wdata;
  logic [3:0]  al_be;
  logic        al_illegal;

  logic accept, store_go, store_bad, timeout_hit;

  store_lane_align u_align (
    .addr_i    (mem_addr),
    .size_i    (mem_size),
    .wdata_i   (mem_wdata),
    .addr_o    (al_addr),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .illegal_o (al_illegal)
  );

  assign accept    = in_valid && in_ready;
  assign store_go  = accept && write_M && !al_illegal && (state_q == IDLE);
  assign store_bad = accept && write_M && al_illegal;

  // The limit fires on the last REQ cycle without ack, so dmem_req is high
  // for exactly ACK_TIMEOUT cycles. An ack in that same cycle takes priority.
  if (ACK_TIMEOUT != 0) begin : g_timeout
    assign timeout_hit = (state_q == REQ) && !dmem_ack &&
                         (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rst) begin
      state_q  <= IDLE;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    case (state_q)
      IDLE: begin
        if (store_go) begin
          state_d  = REQ;
          to_cnt_d = '0;
        end
      end
      REQ: begin
        if (dmem_ack || timeout_hit) state_d = IDLE;
        else                         to_cnt_d = to_cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dmem_req = (state_q == REQ);
`ifdef WB_STORE_BUF_EN
    // Only a second store is held off while one is outstanding.
    in_ready = !((state_q == REQ) && in_valid && write_M);
`else
    in_ready = (state_q == IDLE);
`endif
  end

  // Register-file path, store payload and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= '0;
      err_misalign_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      // x0 is hard-wired zero, so writes to it are suppressed.
      rf_we_q <= accept && write_R && (rd != 5'd0);
      if (accept && write_R) begin
        rf_waddr_q <= rd;
        rf_wdata_q <= reg_data;
      end
      // Payload is captured only on entry to REQ so it holds until ack.
      if (store_go) begin
        dmem_addr_q  <= al_addr;
        dmem_wdata_q <= al_wdata;
        dmem_be_q    <= al_be;
      end
      err_misalign_q <= store_bad;
      err_timeout_q  <= timeout_hit;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign err_misalign = err_misalign_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_wb_commit.sv
// ---------------------------------------------------------------------------
// tb_wb_commit
// Self-checking bench for wb_commit (ACK_TIMEOUT = 4). Register writes and
// store requests are checked by a negedge monitor against scoreboard queues
// filled by the scenario tasks; handshake, error and timing behaviour is
// checked inline in each task. Honours `WB_STORE_BUF_EN.
// ---------------------------------------------------------------------------
module tb_wb_commit;
  import wb_pkg::*;

  localparam int TO = 4;
`ifdef WB_STORE_BUF_EN
  localparam logic RDY_IN_REQ = 1'b1;
`else
  localparam logic RDY_IN_REQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, write_R = 1'b0, write_M = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] reg_data = '0, mem_addr = '0, mem_wdata = '0;
  logic [1:0]  mem_size = '0;
  logic        dmem_ack = 1'b0;
  logic        in_ready, rf_we, dmem_req, err_misalign, err_timeout;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } rf_exp_t;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } st_exp_t;

  rf_exp_t rf_q[$];
  st_exp_t st_q[$];
  rf_exp_t rf_e;
  st_exp_t st_e;
  logic    req_prev = 1'b0;

  wb_commit #(.ACK_TIMEOUT(TO), .TO_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .write_R      (write_R),
    .write_M      (write_M),
    .rd           (rd),
    .reg_data     (reg_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .dmem_req     (dmem_req),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .err_misalign (err_misalign),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every rf write and every new store request must
  // match the oldest pending expectation.
  always @(negedge clk) begin
    if (rf_we === 1'b1) begin
      checks++;
      if (rf_q.size() == 0) begin
        failures++;
        $display("FAIL rf_unexpected waddr=%0d wdata=%h required no write", rf_waddr, rf_wdata);
      end else begin
        rf_e = rf_q.pop_front();
        if (rf_waddr !== rf_e.a || rf_wdata !== rf_e.d || cyc !== rf_e.c) begin
          failures++;
          $display("FAIL rf_write got a=%0d d=%h cyc=%0d required a=%0d d=%h cyc=%0d",
                   rf_waddr, rf_wdata, cyc, rf_e.a, rf_e.d, rf_e.c);
        end
      end
    end
    if (dmem_req === 1'b1 && req_prev !== 1'b1) begin
      checks++;
      if (st_q.size() == 0) begin
        failures++;
        $display("FAIL store_unexpected addr=%h required no request", dmem_addr);
      end else begin
        st_e = st_q.pop_front();
        if (dmem_addr !== st_e.a || dmem_be !== st_e.be || dmem_wdata !== st_e.d) begin
          failures++;
          $display("FAIL store_req got a=%h be=%b d=%h required a=%h be=%b d=%h",
                   dmem_addr, dmem_be, dmem_wdata, st_e.a, st_e.be, st_e.d);
        end
      end
    end
    req_prev = dmem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Present one transfer and hold it until accepted (bounded).
  // acc_cyc is the cycle number before the accepting edge, -1 if never accepted.
  task automatic xfer(input logic wr, input logic wm, input logic [4:0] r,
                      input logic [31:0] rdat, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz,
                      output int acc_cyc);
    int waited;
    @(negedge clk);
    in_valid = 1'b1; write_R = wr; write_M = wm; rd = r; reg_data = rdat;
    mem_addr = a; mem_wdata = wd; mem_size = sz;
    #1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL xfer_accept in_ready=%b required 1 within 50 cycles", in_ready);
      acc_cyc = -1;
    end else begin
      acc_cyc = cyc;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; write_R = 1'b0; write_M = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Store, then ack on its n-th REQ cycle; checks hold time and completion.
  task automatic store_ack(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                           input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ewd,
                           input int n, input string name);
    int c;
    int held;
    xfer(1'b0, 1'b1, 5'd0, 32'h0, a, wd, sz, c);
    st_q.push_back('{ea, ebe, ewd});
    held = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (dmem_req === 1'b1 && in_ready === RDY_IN_REQ && dmem_addr === ea &&
          dmem_be === ebe && dmem_wdata === ewd) held++;
      if (k == n) dmem_ack = 1'b1;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if (held !== n) begin
      failures++;
      $display("FAIL %s_hold stable_cycles=%0d required %0d", name, held, n);
    end
    checks++;
    if (dmem_req !== 1'b0 || in_ready !== 1'b1 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL %s_done req=%b rdy=%b err_to=%b required 0 1 0",
               name, dmem_req, in_ready, err_timeout);
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl rdy=%b rf_we=%b req=%b required 1 0 0", in_ready, rf_we, dmem_req);
    end
    checks++;
    if (dmem_addr !== 32'h0 || dmem_be !== 4'h0 || dmem_wdata !== 32'h0 ||
        rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || err_misalign !== 1'b0 || err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_data addr=%h be=%b wd=%h ra=%0d rd=%h em=%b et=%b required all 0",
               dmem_addr, dmem_be, dmem_wdata, rf_waddr, rf_wdata, err_misalign, err_timeout);
    end
  endtask

  task automatic test_reg_write;
    int c;
    xfer(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0, 32'h0, SZ_W, c);
    rf_q.push_back('{5'd5, 32'hDEAD_BEEF, c + 1});
    xfer(1'b1, 1'b0, 5'd0, 32'h1111_2222, 32'h0, 32'h0, SZ_W, c);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0) begin
      failures++;
      $display("FAIL reg_x0 rf_we=%b required 0", rf_we);
    end
  endtask

  task automatic test_back_to_back;
    int c;
    for (int i = 1; i <= 4; i++) begin
      xfer(1'b1, 1'b0, 5'(i + 10), 32'hA5A5_0000 + 32'(i), 32'h0, 32'h0, SZ_W, c);
      rf_q.push_back('{5'(i + 10), 32'hA5A5_0000 + 32'(i), c + 1});
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready idx=%0d rdy=%b required 1", i, in_ready);
      end
    end
    xfer(1'b0, 1'b0, 5'd3, 32'h0, 32'h1000, 32'h0, SZ_W, c);
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || dmem_req !== 1'b0 || err_misalign !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL no_enable rf_we=%b req=%b em=%b rdy=%b required 0 0 0 1",
               rf_we, dmem_req, err_misalign, in_ready);
    end
  endtask

  task automatic test_stores;
    store_ack(32'h0000_1003, 32'h0000_00AB, SZ_B, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 3, "byte");
    store_ack(32'h0000_2002, 32'h1234_5678, SZ_H, 32'h0000_2000, 4'b1100, 32'h5678_5678, 1, "half");
    store_ack(32'h0000_2404, 32'hCAFE_F00D, SZ_W, 32'h0000_2404, 4'b1111, 32'hCAFE_F00D, 2, "word");
    // Ack on the very cycle the limit is reached: ack wins, no timeout.
    store_ack(32'h0000_2500, 32'h0000_0077, SZ_B, 32'h0000_2500, 4'b0001, 32'h7777_7777, TO, "ack_at_limit");
  endtask

  task automatic test_misalign;
    int c;
    xfer(1'b1, 1'b1, 5'd7, 32'h1234_5678, 32'h0000_2001, 32'h0000_BEEF, SZ_H, c);
    rf_q.push_back('{5'd7, 32'h1234_5678, c + 1});
    @(negedge clk);
    checks++;
    if (err_misalign !== 1'b1 || dmem_req !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL misalign_half em=%b req=%b rdy=%b required 1 0 1", err_misalign, dmem_req, in_ready);
    end
    @(negedge clk);
    checks++;
    if (err_misalign !== 1'b0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_pulse em=%b req=%b required 0 0", err_misalign, dmem_req);
    end
    xfer(1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_4000, 32'h0, 2'b11, c);
    @(negedge clk);
    checks++;
    if (err_misalign !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_size11 em=%b req=%b required 1 0", err_misalign, dmem_req);
    end
    xfer(1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_2002, 32'h0, SZ_W, c);
    @(negedge clk);
    checks++;
    if (err_misalign !== 1'b1 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL misalign_word em=%b req=%b required 1 0", err_misalign, dmem_req);
    end
  endtask

  task automatic test_timeout;
    int c;
    int held;
    int pulses;
    logic err_at;
    xfer(1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_3000, 32'h0BAD_0BAD, SZ_W, c);
    st_q.push_back('{32'h0000_3000, 4'b1111, 32'h0BAD_0BAD});
    held = 0; pulses = 0; err_at = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (dmem_req === 1'b1) held++;
      if (err_timeout === 1'b1) pulses++;
      if (k == TO + 1) err_at = err_timeout;
    end
    checks++;
    if (held !== TO) begin
      failures++;
      $display("FAIL timeout_req_cycles got=%0d required %0d", held, TO);
    end
    checks++;
    if (pulses !== 1 || err_at !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse count=%0d at_drop=%b required 1 1", pulses, err_at);
    end
    store_ack(32'h0000_3004, 32'h0000_0102, SZ_H, 32'h0000_3004, 4'b0011, 32'h0102_0102, 1, "after_timeout");
  endtask

  task automatic test_reset_in_req;
    int c;
    int bad;
    xfer(1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_6000, 32'h6666_6666, SZ_W, c);
    st_q.push_back('{32'h0000_6000, 4'b1111, 32'h6666_6666});
    @(negedge clk);            // REQ cycle 1
    @(negedge clk);            // REQ cycle 2
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (dmem_req !== 1'b0 || in_ready !== 1'b1 || err_timeout !== 1'b0 ||
          err_misalign !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_in_req bad_cycles=%0d req=%b rdy=%b et=%b required 0 0 1 0",
               bad, dmem_req, in_ready, err_timeout);
    end
  endtask

  task automatic test_store_buf;
`ifdef WB_STORE_BUF_EN
    int c;
    xfer(1'b0, 1'b1, 5'd0, 32'h0, 32'h0000_5000, 32'h1122_3344, SZ_W, c);
    st_q.push_back('{32'h0000_5000, 4'b1111, 32'h1122_3344});
    xfer(1'b1, 1'b0, 5'd9, 32'hCAFE_0009, 32'h0, 32'h0, SZ_B, c);
    rf_q.push_back('{5'd9, 32'hCAFE_0009, c + 1});
    @(negedge clk);
    in_valid = 1'b1; write_M = 1'b1; mem_addr = 32'h0000_5004;
    mem_wdata = 32'h5566_7788; mem_size = SZ_W;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL buf_hold1 rdy=%b required 0", in_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b0 || dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL buf_hold2 rdy=%b req=%b required 0 1", in_ready, dmem_req);
    end
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL buf_release rdy=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; write_M = 1'b0;
    st_q.push_back('{32'h0000_5004, 4'b1111, 32'h5566_7788});
    @(negedge clk);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL buf_second_done req=%b required 0", dmem_req);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_back_to_back();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_in_req();
    test_store_buf();
    repeat (3) @(negedge clk);
    checks++;
    if (rf_q.size() != 0 || st_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain rf_pending=%0d st_pending=%0d required 0 0",
               rf_q.size(), st_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
